// File: rtl/chan_link_pkg.sv
// Shared definitions for the channel-link readout path: FSM encoding, frame width
// and default sizing constants.
package chan_link_pkg;

  localparam int FRAME_W           = 16;
  localparam int DEF_WORDS_PER_EVT = 96;
  localparam int DEF_EVT_Q_DEPTH   = 8;
  localparam int DEF_GAP_CYC       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_GAP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/evt_pend_cnt.sv
// Saturating up/down counter of pending events with a sticky overflow flag that
// records any increment dropped because the queue was already full.
module evt_pend_cnt #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_ovf
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_drop;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_cnt_nxt = r_cnt;
    w_drop    = 1'b0;
    if (i_inc && !i_dec) begin
      if (r_cnt == CNT_W'(DEPTH)) w_drop = 1'b1;
      else                        w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/chan_link_rdout_ctrl.sv
// Readout sequencer: queues L1A-matched events, reads one frame per event out of the
// sample FIFO and presents it as a registered word stream for the channel-link driver.
module chan_link_rdout_ctrl
  import chan_link_pkg::*;
#(
  parameter int WORDS_PER_EVT = DEF_WORDS_PER_EVT,
  parameter int EVT_Q_DEPTH   = DEF_EVT_Q_DEPTH,
  parameter int GAP_CYC       = DEF_GAP_CYC,
  parameter int PEND_W        = $clog2(EVT_Q_DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_l1a_match,
  input  logic               i_fifo_empty,
  input  logic [FRAME_W-1:0] i_fifo_dout,
  output logic               o_fifo_rd,
  output logic [FRAME_W-1:0] o_frame_data,
  output logic               o_dvalid,
  output logic               o_last_wrd,
  output logic               o_ovlp_mux,
  output logic               o_mlt_ovlp,
  output logic               o_busy,
  output logic [PEND_W-1:0]  o_pending,
  output logic               o_evt_ovf
);

  localparam int WCNT_W = $clog2(WORDS_PER_EVT);
  localparam int GCNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  rd_state_e          r_state, w_state_nxt;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [GCNT_W-1:0]  r_gcnt;
  logic [PEND_W-1:0]  w_pend_nxt;
  logic               w_pend_nz, w_gap_done, w_rd_last, w_start, w_busy_raw;
  logic               r_rd_d, r_last_d, r_busy_d, r_busy_dd;
  logic               r_dvalid, r_last_wrd, r_ovlp_mux, r_mlt_ovlp;
  logic [FRAME_W-1:0] r_frame_data;

  evt_pend_cnt #(
    .DEPTH (EVT_Q_DEPTH),
    .CNT_W (PEND_W)
  ) u_pend (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (i_l1a_match),
    .i_dec     (w_start),
    .o_cnt     (o_pending),
    .o_cnt_nxt (w_pend_nxt),
    .o_ovf     (o_evt_ovf)
  );

  assign w_pend_nz  = (o_pending != '0);
  assign w_gap_done = (r_gcnt == GCNT_W'(GAP_CYC - 1));
  assign w_rd_last  = o_fifo_rd && (r_wcnt == WCNT_W'(WORDS_PER_EVT - 1));
  assign w_start    = (w_state_nxt == ST_RD) && (r_state != ST_RD);
  assign w_busy_raw = (r_state != ST_IDLE) || w_pend_nz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pend_nz) w_state_nxt = ST_RD;
      ST_RD:   if (w_rd_last) w_state_nxt = ST_GAP;
      ST_GAP:  if (w_gap_done) w_state_nxt = w_pend_nz ? ST_RD : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_fifo_rd = (r_state == ST_RD) && !i_fifo_empty;
  end

  // Word counter advances only on actual reads, so FIFO_EMPTY simply stalls the frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wcnt <= '0;
      r_gcnt <= '0;
    end else begin
      if (w_rd_last)      r_wcnt <= '0;
      else if (o_fifo_rd) r_wcnt <= r_wcnt + WCNT_W'(1);
      if (r_state == ST_GAP && !w_gap_done) r_gcnt <= r_gcnt + GCNT_W'(1);
      else                                  r_gcnt <= '0;
    end
  end

  // Two-stage output pipe: FIFO data arrives one cycle after the read, then is registered.
  // BUSY rides the same pipe so it stays aligned with the word stream it describes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_d       <= 1'b0;
      r_last_d     <= 1'b0;
      r_busy_d     <= 1'b0;
      r_busy_dd    <= 1'b0;
      r_dvalid     <= 1'b0;
      r_last_wrd   <= 1'b0;
      r_frame_data <= '0;
      r_ovlp_mux   <= 1'b0;
      r_mlt_ovlp   <= 1'b0;
    end else begin
      r_rd_d     <= o_fifo_rd;
      r_last_d   <= w_rd_last;
      r_busy_d   <= w_busy_raw;
      r_busy_dd  <= r_busy_d;
      r_dvalid   <= r_rd_d;
      r_last_wrd <= r_last_d;
      if (r_rd_d) r_frame_data <= i_fifo_dout;
      // A new start in the previous frame's LAST_WRD cycle takes priority over the clear.
      if (w_start) begin
        r_ovlp_mux <= (r_state == ST_GAP);
        r_mlt_ovlp <= (w_pend_nxt != '0);
      end else if (r_last_wrd) begin
        r_ovlp_mux <= 1'b0;
        r_mlt_ovlp <= 1'b0;
      end
    end
  end

  assign o_frame_data = r_frame_data;
  assign o_dvalid     = r_dvalid;
  assign o_last_wrd   = r_last_wrd;
  assign o_ovlp_mux   = r_ovlp_mux;
  assign o_mlt_ovlp   = r_mlt_ovlp;
  assign o_busy       = r_busy_dd;

endmodule

// File: tb/tb_chan_link_rdout_ctrl.sv
// Scoreboard bench for chan_link_rdout_ctrl: expected frames are queued when events are
// issued and a negedge monitor compares every DVALID word against the queue.
module tb_chan_link_rdout_ctrl;
  import chan_link_pkg::*;

  localparam int WPE = 96;
  localparam int QD  = 8;
  localparam int GAP = 2;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        ovlp;
    logic        mlt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, l1a, fifo_empty;
  logic [15:0] fifo_dout = '0;
  logic        fifo_rd, dvalid, last_wrd, ovlp_mux, mlt_ovlp, busy, evt_ovf;
  logic [15:0] frame_data;
  logic [3:0]  pending;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          words_seen = 0;
  int          last_wrd_cyc = 0;
  logic        first_of_frame = 1'b1;
  logic [15:0] fifo_ptr = 16'hA000;
  logic [15:0] exp_ptr  = 16'hA000;
  exp_t        sb_q[$];
  exp_t        e;

  int          first_rd, last_rd, rd_cnt, rd_hole, first_dv, dv_cnt, lw_cyc, lw_cnt;
  logic        busy_log[0:255];

  chan_link_rdout_ctrl #(
    .WORDS_PER_EVT (WPE),
    .EVT_Q_DEPTH   (QD),
    .GAP_CYC       (GAP)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_l1a_match  (l1a),
    .i_fifo_empty (fifo_empty),
    .i_fifo_dout  (fifo_dout),
    .o_fifo_rd    (fifo_rd),
    .o_frame_data (frame_data),
    .o_dvalid     (dvalid),
    .o_last_wrd   (last_wrd),
    .o_ovlp_mux   (ovlp_mux),
    .o_mlt_ovlp   (mlt_ovlp),
    .o_busy       (busy),
    .o_pending    (pending),
    .o_evt_ovf    (evt_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample FIFO model: sequential data, word valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_dout <= fifo_ptr;
      fifo_ptr  <= fifo_ptr + 16'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic ovlp, input logic mlt);
    for (int i = 0; i < WPE; i++) begin
      exp_t x;
      x.data = exp_ptr + 16'(i);
      x.last = (i == WPE - 1);
      x.ovlp = ovlp;
      x.mlt  = mlt;
      sb_q.push_back(x);
    end
    exp_ptr = exp_ptr + 16'(WPE);
  endtask

  // Monitor: every DVALID word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && dvalid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_dvalid", dvalid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("data", frame_data, e.data);
        check("last_wrd", last_wrd, e.last);
        check("ovlp_mux", ovlp_mux, e.ovlp);
        check("mlt_ovlp", mlt_ovlp, e.mlt);
        if (first_of_frame && e.ovlp) check("b2b_gap", cyc - last_wrd_cyc, GAP + 1);
        first_of_frame = e.last;
        if (last_wrd) last_wrd_cyc = cyc;
      end
      words_seen++;
    end else if (!rst && last_wrd) begin
      check("last_wo_dvalid", last_wrd, 1'b0);
    end
  end

  // Drives one L1A at relative cycle 10 and an optional FIFO_EMPTY window, logging timing.
  task automatic run_window(input int n, input int e_from, input int e_to);
    first_rd = -1; last_rd = -1; rd_cnt = 0; rd_hole = 0;
    first_dv = -1; dv_cnt = 0; lw_cyc = -1; lw_cnt = 0;
    for (int rel = 0; rel < n; rel++) begin
      @(negedge clk);
      l1a        = (rel == 10);
      fifo_empty = (rel >= e_from) && (rel < e_to);
      #1;
      if (fifo_rd) begin
        if (first_rd < 0) first_rd = rel;
        last_rd = rel;
        rd_cnt++;
        if (rel >= e_from && rel < e_to) rd_hole++;
      end
      if (dvalid) begin
        if (first_dv < 0) first_dv = rel;
        dv_cnt++;
      end
      if (last_wrd) begin
        lw_cyc = rel;
        lw_cnt++;
      end
      if (rel < 256) busy_log[rel] = busy;
    end
    l1a = 1'b0;
    fifo_empty = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) break;
    end
    check("drain_queue", sb_q.size(), 0);
    check("idle_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; l1a = 1'b0; fifo_empty = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dvalid", dvalid, 1'b0);
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pending", pending, 4'd0);
    check("rst_evt_ovf", evt_ovf, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: single event, nominal latency and BUSY release
    push_frame(1'b0, 1'b0);
    run_window(116, 0, 0);
    check("t1_first_rd", first_rd, 12);
    check("t1_last_rd", last_rd, 107);
    check("t1_rd_cnt", rd_cnt, WPE);
    check("t1_first_dv", first_dv, 14);
    check("t1_dv_cnt", dv_cnt, WPE);
    check("t1_last_wrd_at", lw_cyc, 109);
    check("t1_last_wrd_cnt", lw_cnt, 1);
    check("t1_busy_111", busy_log[111], 1'b1);
    check("t1_busy_112", busy_log[112], 1'b0);
    wait_idle(200);

    // 2 + 5: three back-to-back events; L1A coincident with frame start leaves PENDING as is
    push_frame(1'b0, 1'b1);
    push_frame(1'b1, 1'b1);
    push_frame(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    l1a = 1'b1;
    @(negedge clk); #1;
    check("t2_pend_c11", pending, 4'd1);
    @(negedge clk); #1;
    check("t5_pend_coincident", pending, 4'd1);
    @(negedge clk);
    l1a = 1'b0;
    #1;
    check("t2_pend_c13", pending, 4'd2);
    wait_idle(600);

    // 3: five-cycle FIFO_EMPTY stall mid-frame
    push_frame(1'b0, 1'b0);
    run_window(122, 40, 45);
    check("t3_rd_cnt", rd_cnt, WPE);
    check("t3_rd_hole", rd_hole, 0);
    check("t3_last_rd", last_rd, 112);
    check("t3_first_dv", first_dv, 14);
    check("t3_dv_cnt", dv_cnt, WPE);
    check("t3_last_wrd_at", lw_cyc, 114);
    check("t3_dv_span", lw_cyc - first_dv + 1, WPE + 5);
    wait_idle(200);

    // 4: one active frame plus nine L1As -> eight queued, one dropped
    push_frame(1'b0, 1'b0);
    for (int k = 0; k < QD - 1; k++) push_frame(1'b1, 1'b1);
    push_frame(1'b1, 1'b0);
    for (int rel = 0; rel < 32; rel++) begin
      @(negedge clk);
      l1a = (rel == 10) || (rel >= 20 && rel <= 28);
      #1;
      if (rel == 30) begin
        check("t4_pend_sat", pending, 4'd8);
        check("t4_evt_ovf", evt_ovf, 1'b1);
      end
    end
    l1a = 1'b0;
    wait_idle(2000);
    check("t4_ovf_sticky", evt_ovf, 1'b1);

    // 6: reset mid-frame at word 40
    push_frame(1'b0, 1'b0);
    begin
      int w0;
      w0 = words_seen;
      @(negedge clk); l1a = 1'b1;
      @(negedge clk); l1a = 1'b0;
      for (int i = 0; i < 400 && words_seen < w0 + 40; i++) @(negedge clk);
      check("t6_word40_reached", (words_seen >= w0 + 40), 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    check("t6_rst_dvalid", dvalid, 1'b0);
    check("t6_rst_last", last_wrd, 1'b0);
    check("t6_rst_fifo_rd", fifo_rd, 1'b0);
    check("t6_rst_data", frame_data, 16'h0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_pending", pending, 4'd0);
    check("t6_rst_ovlp", ovlp_mux, 1'b0);
    check("t6_rst_evt_ovf", evt_ovf, 1'b0);
    sb_q.delete();
    first_of_frame = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ptr = fifo_ptr;
    repeat (30) @(negedge clk);
    check("t6_post_busy", busy, 1'b0);
    check("t6_post_pending", pending, 4'd0);
    check("t6_post_evt_ovf", evt_ovf, 1'b0);

    // Fresh frame after reset resumes from the untouched FIFO contents
    push_frame(1'b0, 1'b0);
    l1a = 1'b1;
    @(negedge clk);
    l1a = 1'b0;
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
